ripple_carry_adder: RTL and testbench
=====================================

// Module: ripple_carry_adder
//
// PURPOSE
//   WIDTH-bit unsigned/two's-complement adder built as an explicit chain of
//   1-bit full adders (ripple carry), computing A + B + carry-in.
//   Result, carry-out and signed overflow are registered; one cycle latency.
//   Arithmetic datapath leaf of the 8-bit ALU; the ALU instantiates it with WIDTH=8.
//
// PARAMETERS
//   WIDTH   8   operand/sum width in bits (>= 2)
//
// PORTS
//   clk        in   1      system clock; all state updates on rising edge
//   rst_n      in   1      synchronous, active-low reset
//   in_valid   in   1      operands/carryIn valid this cycle; capture result
//   operandA   in   WIDTH  addend A
//   operandB   in   WIDTH  addend B
//   carryIn    in   1      carry into bit 0
//   out_valid  out  1      sum/carryOut/overflow hold a new result this cycle
//   sum        out  WIDTH  registered (A + B + carryIn) mod 2^WIDTH
//   carryOut   out  1      registered carry out of bit WIDTH-1
//   overflow   out  1      registered signed overflow: carry into MSB XOR carry out of MSB
//
// BEHAVIOUR
//   - Combinational core: generate loop of WIDTH full-adder cells.
//     c[0]=carryIn; s[i]=a[i]^b[i]^c[i]; c[i+1]=a[i]&b[i] | c[i]&(a[i]^b[i]).
//     No carry-lookahead or behavioural '+' in the core.
//   - Reset: rst_n sampled low at a rising clk edge -> sum=0, carryOut=0,
//     overflow=0, out_valid=0 at that edge. Reset wins over in_valid at the same edge.
//   - Latency 1: inputs sampled at edge N with in_valid=1 -> results visible
//     after edge N, out_valid=1 for exactly that cycle.
//   - in_valid=0 at an edge: out_valid=0; sum/carryOut/overflow hold last values.
//   - Back-to-back in_valid: new result every cycle, no bubbles, no backpressure.
//   - Wrap-around: results exceeding 2^WIDTH-1 wrap mod 2^WIDTH; carryOut=1.
//   - overflow meaningful for signed interpretation only; computed regardless.
//   - Reset asserted mid-stream: an operation sampled at the reset edge is
//     discarded; first valid result follows the first in_valid edge after release.
//   - Inputs X/Z not handled; the bench drives defined values only.
//
// TESTING
//   1) rst_n=0 one edge -> sum=00, carryOut=0, overflow=0, out_valid=0.
//   2) A=AA, B=55, cin=0, in_valid=1 -> next cycle sum=FF, cout=0, ovf=0, out_valid=1.
//   3) A=0F, B=01, cin=0 -> sum=10, cout=0;  A=25(d), B=31(d) -> sum=56(d)=38h, cout=0.
//   4) A=FF, B=01, cin=0 -> sum=00, cout=1, ovf=0;  A=FF, B=00, cin=1 -> sum=00, cout=1.
//   5) A=7F, B=01 -> sum=80, ovf=1, cout=0;  A=80, B=80 -> sum=00, ovf=1, cout=1.
//   6) Back-to-back valids then in_valid=0 -> outputs hold, out_valid=0;
//      rst_n=0 together with in_valid=1 -> outputs cleared, no result emitted.
//   Plus: random sweep vs. golden {cout,sum} = A+B+cin over >=10k vectors, WIDTH=8 and 16.

Source files
------------

// File: rtl/ripple_carry_adder.sv
// Ripple-carry adder: WIDTH full-adder cells chained bit 0 -> MSB,
// result/carry/overflow registered with a one-cycle valid strobe.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   in_valid  operandA/operandB/carryIn valid, capture result
//   operandA  addend A
//   operandB  addend B
//   carryIn   carry into bit 0
//   out_valid new result present this cycle
//   sum       registered (A + B + carryIn) mod 2^WIDTH
//   carryOut  registered carry out of the MSB
//   overflow  registered signed overflow (carry into MSB ^ carry out)

module fullAdderCell (
  input  logic a,
  input  logic b,
  input  logic cIn,
  output logic s,
  output logic cOut
);

  logic halfSum;

  assign halfSum = a ^ b;
  assign s       = halfSum ^ cIn;
  assign cOut    = (a & b) | (cIn & halfSum);

endmodule

module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             carryIn,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
  output logic             overflow
);

  // carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sumComb;
  logic             ovfComb;

  assign carry[0] = carryIn;

  for (genvar i = 0; i < WIDTH; i++) begin : gCell
    fullAdderCell uCell (
      .a    (operandA[i]),
      .b    (operandB[i]),
      .cIn  (carry[i]),
      .s    (sumComb[i]),
      .cOut (carry[i+1])
    );
  end

  assign ovfComb = carry[WIDTH] ^ carry[WIDTH-1];

  // Reset dominates in_valid, so an operation presented at the
  // reset edge never produces a result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carryOut  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum      <= sumComb;
        carryOut <= carry[WIDTH];
        overflow <= ovfComb;
      end
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Bench for ripple_carry_adder at WIDTH=8 and WIDTH=16:
// directed corner cases then a random sweep against an arithmetic model.

module tb_ripple_carry_adder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        iv8;
  logic [7:0]  a8, b8;
  logic        c8;
  logic        ov8;
  logic [7:0]  s8;
  logic        co8, of8;

  logic        iv16;
  logic [15:0] a16, b16;
  logic        c16;
  logic        ov16;
  logic [15:0] s16;
  logic        co16, of16;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  ripple_carry_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .operandA  (a8),
    .operandB  (b8),
    .carryIn   (c8),
    .out_valid (ov8),
    .sum       (s8),
    .carryOut  (co8),
    .overflow  (of8)
  );

  ripple_carry_adder #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv16),
    .operandA  (a16),
    .operandB  (b16),
    .carryIn   (c16),
    .out_valid (ov16),
    .sum       (s16),
    .carryOut  (co16),
    .overflow  (of16)
  );

  // Packed views: {out_valid, overflow, carryOut, sum}
  function automatic logic [31:0] obs8();
    return 32'({ov8, of8, co8, s8});
  endfunction

  function automatic logic [31:0] obs16();
    return 32'({ov16, of16, co16, s16});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dir8(input string tag, input logic [7:0] a,
                      input logic [7:0] b, input logic cin,
                      input logic [7:0] eSum, input logic eCout,
                      input logic eOvf);
    iv8 = 1'b1;
    a8  = a;
    b8  = b;
    c8  = cin;
    @(posedge clk);
    #1;
    chk(tag, obs8(), 32'({1'b1, eOvf, eCout, eSum}));
  endtask

  initial begin
    logic        mV8, mO8, mC8;
    logic [7:0]  mS8;
    logic        mV16, mO16, mC16;
    logic [15:0] mS16;
    logic [8:0]  t8;
    logic [16:0] t16;

    rst_n = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
    iv16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;
    @(posedge clk);
    #1;
    chk("reset8", obs8(), 32'h0);
    chk("reset16", obs16(), 32'h0);
    rst_n = 1'b1;

    dir8("aa_55", 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0);
    dir8("0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    dir8("25_31", 8'd25, 8'd31, 1'b0, 8'h38, 1'b0, 1'b0);
    dir8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    dir8("ff_00_c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    dir8("7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    dir8("80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    dir8("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    dir8("7f_7f", 8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1);

    // Hold: last result (7F+7F) stays, valid drops
    iv8 = 1'b0;
    a8  = 8'h12;
    b8  = 8'h34;
    @(posedge clk);
    #1;
    chk("hold1", obs8(), 32'({1'b0, 1'b1, 1'b0, 8'hFE}));
    @(posedge clk);
    #1;
    chk("hold2", obs8(), 32'({1'b0, 1'b1, 1'b0, 8'hFE}));

    // 16-bit wrap boundary
    iv16 = 1'b1;
    a16  = 16'hFFFF;
    b16  = 16'h0001;
    c16  = 1'b0;
    @(posedge clk);
    #1;
    chk("w16_wrap", obs16(), 32'({1'b1, 1'b0, 1'b1, 16'h0000}));
    iv16 = 1'b0;

    // Reset with in_valid high: operation discarded
    rst_n = 1'b0;
    iv8   = 1'b1;
    a8    = 8'h01;
    b8    = 8'h01;
    c8    = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_iv8", obs8(), 32'h0);
    chk("rst_iv16", obs16(), 32'h0);
    rst_n = 1'b1;
    iv8   = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst", obs8(), 32'h0);

    // Random sweep; model regs start from reset state
    mV8 = 1'b0; mO8 = 1'b0; mC8 = 1'b0; mS8 = '0;
    mV16 = 1'b0; mO16 = 1'b0; mC16 = 1'b0; mS16 = '0;
    for (int i = 0; i < 14000; i++) begin
      iv8  = ($urandom_range(0, 3) != 0);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      c8   = 1'($urandom);
      iv16 = ($urandom_range(0, 3) != 0);
      a16  = 16'($urandom);
      b16  = 16'($urandom);
      c16  = 1'($urandom);

      mV8 = iv8;
      if (iv8) begin
        t8  = 9'(a8) + 9'(b8) + 9'(c8);
        mS8 = t8[7:0];
        mC8 = t8[8];
        mO8 = (a8[7] == b8[7]) && (t8[7] != a8[7]);
      end
      mV16 = iv16;
      if (iv16) begin
        t16  = 17'(a16) + 17'(b16) + 17'(c16);
        mS16 = t16[15:0];
        mC16 = t16[16];
        mO16 = (a16[15] == b16[15]) && (t16[15] != a16[15]);
      end

      @(posedge clk);
      #1;
      chk("rand8", obs8(), 32'({mV8, mO8, mC8, mS8}));
      chk("rand16", obs16(), 32'({mV16, mO16, mC16, mS16}));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
